cv32e40x_data_obi_arbiter: RTL

// - Shares one data OBI transaction port between two requesters: port 0 = LSU, port 1 = auxiliary master (e.g. XIF mem).
// - Sits between the requesters and the data OBI interface adapter.
// - Arbitrates A-channel requests and holds the selection stable until granted.
// - Records the owner of each accepted transaction in an in-order ID FIFO and routes R-channel responses back to that owner.
//

---
 rtl/cv32e40x_data_obi_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cv32e40x_data_obi_arbiter.sv
// rtl/cv32e40x_data_obi_arbiter.sv - two-port data OBI arbiter with request lock and in-order response routing
// Define CV32E40X_DATA_OBI_ARB_RR_EN for round-robin arbitration; fixed priority (port 0) otherwise.
package cv32e40x_data_obi_arbiter_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_data_resp_t;
endpackage

module cv32e40x_data_obi_arbiter
  import cv32e40x_data_obi_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid_i,
  output logic           req0_ready_o,
  input  obi_data_req_t  req0_i,
  input  logic           req1_valid_i,
  output logic           req1_ready_o,
  input  obi_data_req_t  req1_i,
  output logic           resp0_valid_o,
  output logic           resp1_valid_o,
  output obi_data_resp_t resp_o,
  output logic           trans_valid_o,
  input  logic           trans_ready_i,
  output obi_data_req_t  trans_o,
  input  logic           resp_valid_i,
  input  obi_data_resp_t resp_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_e;

  lock_state_e                state_q, state_d;
  logic                       locked_port_q, locked_port_d;
  logic                       idle_sel;
  logic                       sel;
  logic                       sel_valid;
  logic                       full;
  logic                       trans_valid;
  logic                       accept;
  logic                       pop;
  logic                       head_id;
  logic [CNT_W-1:0]           cnt_q;
  logic [PTR_W-1:0]           wptr_q, rptr_q;
  logic [MAX_OUTSTANDING-1:0] id_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef CV32E40X_DATA_OBI_ARB_RR_EN
  logic rr_ptr_q;

  assign idle_sel = (req0_valid_i && req1_valid_i) ? rr_ptr_q : req1_valid_i;

  // Hand priority to the port that lost the last accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else if (accept) begin
      rr_ptr_q <= !sel;
    end
  end
`else
  assign idle_sel = !req0_valid_i;
`endif

  // Full is taken from the registered count only, so a same-cycle response cannot unblock.
  assign full        = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign sel         = (state_q == LOCKED) ? locked_port_q : idle_sel;
  assign sel_valid   = sel ? req1_valid_i : req0_valid_i;
  assign trans_valid = sel_valid && !full;
  assign accept      = trans_valid && trans_ready_i;

  always_comb begin
    state_d       = state_q;
    locked_port_d = locked_port_q;
    case (state_q)
      IDLE: begin
        if (trans_valid && !trans_ready_i) begin
          state_d       = LOCKED;
          locked_port_d = sel;
        end
      end
      LOCKED: begin
        if (accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      locked_port_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      locked_port_q <= locked_port_d;
    end
  end

  assign pop     = resp_valid_i && (cnt_q != '0);
  assign head_id = id_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      id_q   <= '0;
    end else begin
      if (accept) begin
        id_q[wptr_q] <= sel;
        wptr_q       <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Outputs are forced low while reset is held so they clear immediately.
  assign trans_valid_o = rst_n && trans_valid;
  assign req0_ready_o  = rst_n && !full && trans_ready_i && !sel;
  assign req1_ready_o  = rst_n && !full && trans_ready_i && sel;
  assign trans_o       = rst_n ? (sel ? req1_i : req0_i) : '0;
  assign resp0_valid_o = rst_n && pop && !head_id;
  assign resp1_valid_o = rst_n && pop && head_id;
  assign resp_o        = rst_n ? resp_i : '0;

  a_locked_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == LOCKED) |-> (locked_port_q ? req1_valid_i : req0_valid_i));

  a_no_resp_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid_i |-> (cnt_q != '0));

endmodule
